// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: run states, default opcodes
// and the opcode field location inside the 9-bit instruction word.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned INSTR_W  = 9;
  localparam int unsigned OP_HI    = 8;
  localparam int unsigned OP_LO    = 6;
  localparam int unsigned OP_W     = OP_HI - OP_LO + 1;
  localparam int unsigned RETIRE_W = 16;

  localparam logic [OP_W-1:0] DEF_OP_JUMP   = 3'b111;
  localparam logic [OP_W-1:0] DEF_OP_BRANCH = 3'b110;

  function automatic logic [OP_W-1:0] op_field(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: run handshake, ROM/datapath inputs and program
// counter controls plus run status.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic                start;
  logic [INSTR_W-1:0]  instr;
  logic                flag;
  logic                halt;
  logic                pc_init;
  logic                jump_en;
  logic                branch_en;
  logic [INSTR_W-1:0]  ir;
  logic [RETIRE_W-1:0] retired;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, instr, flag, halt,
    input  pc_init, jump_en, branch_en, ir, retired, busy, done, err
  );

  modport slave (
    input  start, instr, flag, halt,
    output pc_init, jump_en, branch_en, ir, retired, busy, done, err
  );
endinterface

// File: rtl/fetch_ctrl_op_decode.sv
// Combinational opcode decode into program counter jump/branch requests.
module op_decode
  import fetch_ctrl_pkg::*;
#(
  parameter logic [OP_W-1:0] OP_JUMP   = DEF_OP_JUMP,
  parameter logic [OP_W-1:0] OP_BRANCH = DEF_OP_BRANCH
) (
  input  logic            enable,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag,
  output logic            jump_en,
  output logic            branch_en
);

  logic is_jump;

  always_comb begin
    is_jump   = (opcode == OP_JUMP);
    jump_en   = enable && is_jump;
    // jump wins if both opcodes are ever configured identically
    branch_en = enable && !is_jump && (opcode == OP_BRANCH) && flag;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences IDLE/INIT/RUN/DONE, issues
// instructions, counts retirements and enforces a RUN-cycle timeout.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     TIMEOUT   = 1023,
  parameter logic [OP_W-1:0] OP_JUMP   = DEF_OP_JUMP,
  parameter logic [OP_W-1:0] OP_BRANCH = DEF_OP_BRANCH
) (
  input logic         CLK,
  input logic         init_n,
  fetch_ctrl_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t              state;
  logic [CW-1:0]       cyc;
  logic [INSTR_W-1:0]  ir_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                err_q;
  logic                issue;

  assign issue = (state == ST_RUN) && !bus.halt;

  op_decode #(
    .OP_JUMP   (OP_JUMP),
    .OP_BRANCH (OP_BRANCH)
  ) u_dec (
    .enable    (issue),
    .opcode    (op_field(bus.instr)),
    .flag      (bus.flag),
    .jump_en   (bus.jump_en),
    .branch_en (bus.branch_en)
  );

  always_comb begin
    bus.pc_init = (state == ST_INIT);
    bus.busy    = (state == ST_INIT) || (state == ST_RUN);
    bus.done    = (state == ST_DONE);
    bus.ir      = ir_q;
    bus.retired = retired_q;
    bus.err     = err_q;
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state     <= ST_IDLE;
      cyc       <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_INIT;
            retired_q <= '0;
            cyc       <= '0;
            err_q     <= 1'b0;
          end
        end
        ST_INIT: begin
          retired_q <= '0;
          cyc       <= '0;
          err_q     <= 1'b0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          cyc <= cyc + CW'(1);
          if (bus.halt) begin
            state <= ST_DONE;
            err_q <= 1'b0;
          end else begin
            ir_q <= bus.instr;
            if (retired_q != '1) retired_q <= retired_q + RETIRE_W'(1);
            // the timeout cycle still issues; halt in the same cycle wins above
            if (cyc == TMO) begin
              state <= ST_DONE;
              err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            state     <= ST_INIT;
            retired_q <= '0;
            cyc       <= '0;
            err_q     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with TIMEOUT=8: vector table for the main
// run, hand sequences for timeout, halt/timeout collision and mid-run reset.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_init;
    logic       jump_en;
    logic       branch_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] ir;
    logic [15:0] retired;
  } out_t;

  typedef struct packed {
    logic       start;
    logic [8:0] instr;
    logic       flag;
    logic       halt;
    out_t       exp;
  } vec_t;

  logic CLK;
  logic init_n;
  int   nvec;
  int   nmis;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .TIMEOUT   (8),
    .OP_JUMP   (3'b111),
    .OP_BRANCH (3'b110)
  ) dut (
    .CLK    (CLK),
    .init_n (init_n),
    .bus    (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic out_t mk(input logic pi, input logic j, input logic b,
                              input logic bu, input logic d, input logic e,
                              input logic [8:0] ir_e, input logic [15:0] r);
    out_t o;
    o.pc_init = pi; o.jump_en = j; o.branch_en = b;
    o.busy = bu; o.done = d; o.err = e; o.ir = ir_e; o.retired = r;
    return o;
  endfunction

  function automatic vec_t v(input logic s, input logic [8:0] i, input logic f,
                             input logic h, input out_t o);
    vec_t x;
    x.start = s; x.instr = i; x.flag = f; x.halt = h; x.exp = o;
    return x;
  endfunction

  task automatic drive(input logic s, input logic [8:0] i, input logic f, input logic h);
    bus.start = s; bus.instr = i; bus.flag = f; bus.halt = h;
  endtask

  task automatic check(input string name, input out_t e);
    out_t a;
    a = mk(bus.pc_init, bus.jump_en, bus.branch_en, bus.busy, bus.done,
           bus.err, bus.ir, bus.retired);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got pi=%b j=%b b=%b busy=%b done=%b err=%b ir=%h ret=%0d, expected pi=%b j=%b b=%b busy=%b done=%b err=%b ir=%h ret=%0d",
               name, a.pc_init, a.jump_en, a.branch_en, a.busy, a.done, a.err,
               a.ir, a.retired, e.pc_init, e.jump_en, e.branch_en, e.busy,
               e.done, e.err, e.ir, e.retired);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl [12];

  initial begin
    nvec = 0;
    nmis = 0;

    // inputs -> expected outputs sampled mid-cycle (state from earlier edges)
    tbl[0]  = v(0, 9'b111_000001, 1, 0, mk(0,0,0,0,0,0, 9'h000, 0));
    tbl[1]  = v(1, 9'b111_000001, 1, 0, mk(0,0,0,0,0,0, 9'h000, 0));
    tbl[2]  = v(0, 9'b111_000001, 1, 1, mk(1,0,0,1,0,0, 9'h000, 0));
    tbl[3]  = v(0, 9'b110_000000, 1, 0, mk(0,0,1,1,0,0, 9'h000, 0));
    tbl[4]  = v(0, 9'b110_000001, 0, 0, mk(0,0,0,1,0,0, 9'b110_000000, 1));
    tbl[5]  = v(1, 9'b111_000010, 1, 0, mk(0,1,0,1,0,0, 9'b110_000001, 2));
    tbl[6]  = v(0, 9'b000_000011, 1, 0, mk(0,0,0,1,0,0, 9'b111_000010, 3));
    tbl[7]  = v(0, 9'b111_000000, 1, 1, mk(0,0,0,1,0,0, 9'b000_000011, 4));
    tbl[8]  = v(0, 9'b111_000000, 1, 1, mk(0,0,0,0,1,0, 9'b000_000011, 4));
    tbl[9]  = v(0, 9'b110_000000, 1, 0, mk(0,0,0,0,1,0, 9'b000_000011, 4));
    tbl[10] = v(1, 9'b111_000000, 1, 1, mk(0,0,0,0,1,0, 9'b000_000011, 4));
    tbl[11] = v(1, 9'b111_000000, 1, 1, mk(1,0,0,1,0,0, 9'b000_000011, 0));

    init_n = 1'b0;
    drive(0, 9'b111_111111, 1, 1);
    @(posedge CLK);
    #3;
    check("reset", mk(0,0,0,0,0,0, 9'h000, 0));
    init_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].start, tbl[i].instr, tbl[i].flag, tbl[i].halt);
      #2;
      check($sformatf("tbl%0d", i), tbl[i].exp);
      next_cycle();
    end

    // timeout run: 9 RUN cycles with halt low, last one still issues
    for (int k = 0; k < 9; k++) begin
      drive(0, {3'b001, 6'(k)}, 1, 0);
      #2;
      check($sformatf("tmo_run%0d", k),
            mk(0,0,0,1,0,0, (k == 0) ? 9'b000_000011 : {3'b001, 6'(k - 1)}, 16'(k)));
      next_cycle();
    end
    drive(0, 9'h000, 0, 0);
    #2;
    check("tmo_done", mk(0,0,0,0,1,1, {3'b001, 6'd8}, 9));

    // restart from DONE; halt still high through INIT must not exit early
    drive(1, 9'h000, 0, 1);
    #2;
    check("restart_done", mk(0,0,0,0,1,1, {3'b001, 6'd8}, 9));
    next_cycle();
    drive(0, 9'h000, 0, 1);
    #2;
    check("restart_init", mk(1,0,0,1,0,0, {3'b001, 6'd8}, 0));
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      drive(0, {3'b010, 6'(k)}, 1, 0);
      next_cycle();
    end
    drive(0, 9'b111_000000, 1, 1);
    #2;
    check("halt_at_tmo", mk(0,0,0,1,0,0, {3'b010, 6'd7}, 8));
    next_cycle();
    drive(0, 9'h000, 0, 0);
    #2;
    check("halt_prio", mk(0,0,0,0,1,0, {3'b010, 6'd7}, 8));

    // asynchronous reset in the middle of RUN
    drive(1, 9'h000, 0, 0);
    next_cycle();
    drive(0, 9'b111_000101, 1, 0);
    next_cycle();
    #2;
    check("pre_abort", mk(0,1,0,1,0,0, {3'b010, 6'd7}, 0));
    init_n = 1'b0;
    #1;
    check("abort", mk(0,0,0,0,0,0, 9'h000, 0));
    #1;
    init_n = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 9'b111_000101, 1, 0);
      #2;
      check($sformatf("post_abort%0d", k), mk(0,0,0,0,0,0, 9'h000, 0));
      next_cycle();
    end
    drive(1, 9'b110_000000, 1, 0);
    #2;
    check("idle_start", mk(0,0,0,0,0,0, 9'h000, 0));
    next_cycle();
    drive(0, 9'b110_000000, 1, 0);
    #2;
    check("rerun_init", mk(1,0,0,1,0,0, 9'h000, 0));
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1023: RUN-cycle limit before forced stop.
REQ-002 Parameter OP_JUMP, default 3'b111: opcode (instr[8:6]) of the relative backward jump.
REQ-003 Parameter OP_BRANCH, default 3'b110: opcode of the conditional forward branch.
REQ-004 CLK  input  1  sole clock; all state updates on posedge.
REQ-005 init_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request; sampled only in IDLE and DONE.
REQ-007 instr  input  9  instruction word addressed by the current program counter (combinational ROM output).
REQ-008 flag  input  1  branch condition from the datapath.
REQ-009 halt  input  1  halt status from the program counter.
REQ-010 pc_init  output  1  synchronous init to the program counter.
REQ-011 jump_en  output  1  jump request to the program counter.
REQ-012 branch_en  output  1  branch request to the program counter.
REQ-013 ir  output  9  last issued instruction.
REQ-014 retired  output  16  count of issued instructions in the current run.
REQ-015 busy, done, err  output  1 each  run status.

Function
REQ-016 FSM states shall be IDLE, INIT, RUN and DONE.
REQ-017 IDLE: start=1 shall move to INIT; otherwise the FSM shall stay in IDLE.
REQ-018 INIT shall last exactly one cycle: pc_init=1, retired and the cycle counter cleared, then RUN.
REQ-019 INIT shall ignore halt, since it may still hold 1 from the previous run.
REQ-020 RUN with halt=0 shall drive jump_en=1 iff instr[8:6]==OP_JUMP (combinational).
REQ-021 RUN with halt=0 shall drive branch_en=1 iff instr[8:6]==OP_BRANCH and flag=1.
REQ-022 jump_en and branch_en shall never both be 1, and shall be 0 outside RUN.
REQ-023 RUN with halt=0 shall latch ir<=instr and increment retired, saturating at 16'hFFFF.
REQ-024 RUN with halt=1 shall drive jump_en=branch_en=0, leave ir and retired unchanged, and go to DONE with err<=0.
REQ-025 The cycle counter shall increment every RUN cycle.
REQ-026 When the cycle counter equals TIMEOUT while halt=0, the FSM shall go to DONE with err<=1 and that cycle shall still issue normally.
REQ-027 halt=1 and timeout in the same cycle: halt shall take priority, giving err=0.
REQ-028 busy shall be 1 in INIT and RUN and 0 otherwise.
REQ-029 done shall be 1 only in DONE.
REQ-030 DONE shall hold ir, retired and err until start=1, then move to INIT; err shall clear on entry to INIT.
REQ-031 start shall be ignored in INIT and RUN.
REQ-032 Latency start->pc_init shall be 1 cycle; the first instruction shall issue in the cycle after pc_init.

Reset
REQ-033 init_n=0 shall immediately force IDLE, regardless of clock.
REQ-034 During reset: pc_init=0, jump_en=0, branch_en=0, ir=0, retired=0, busy=0, done=0, err=0, and the cycle counter shall be 0.
REQ-035 Reset asserted mid-RUN shall abort the run with no further enable pulses; after release, a new start is required.

Structure
REQ-036 The state enum, OP_JUMP/OP_BRANCH defaults and the opcode field slice [8:6] shall live in a shared package used by the decoder and the datapath.
REQ-037 One sub-module, op_decode, shall hold the combinational opcode-to-enable decode; fetch_ctrl shall own the FSM, counters and registers.

Verification
REQ-038 Reset then start=1 for one cycle -> pc_init=1 in exactly one cycle, busy=1, and the first ir latched the following cycle.
REQ-039 RUN, instr=9'b110_000000, flag=1, halt=0 -> branch_en=1, jump_en=0; with flag=0 -> both 0, retired still +1.
REQ-040 RUN, instr=9'b111_000000, halt=1 -> jump_en=0, next state DONE, done=1, err=0, retired unchanged.
REQ-041 TIMEOUT=8 and halt held 0 -> DONE with err=1 after 9 RUN cycles, retired=9; halt=1 coinciding with the 9th cycle -> err=0.
REQ-042 init_n pulsed low mid-RUN, then released -> all outputs 0 at once, IDLE, no enables until start.
REQ-043 In DONE, start=1 -> INIT, err cleared, retired reset to 0; with halt=1 still high during INIT -> no early exit.
